// File: rtl/wide_add_sequencer_if.sv
// Request/result bundle between a requester and wide_add_sequencer.
// Ports (as seen from the sequencer, slave modport):
//   start, sub, cin  in   request strobe, subtract select, add-mode carry-in
//   a, b             in   W-bit operands (W = 32*WORDS)
//   busy, done       out  operation in progress / one-cycle result-valid pulse
//   sum              out  W-bit result
//   cout, overflow   out  carry out of the top word / signed overflow
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 32 * WORDS;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor. One 32-bit adder is reused for each
// word of a W = 32*WORDS bit operation, least significant word first; the
// carry between words travels only through carry_r.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of wide_add_sequencer_if (request in, result out)

module full_adder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);
  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic          cout_r;
  logic          ovf_r;
  logic          done_r;

  logic [31:0]   a_word_s;
  logic [31:0]   b_word_s;
  logic [31:0]   s_word_s;
  logic          add_cout_s;
  logic          accept_s;
  logic          last_s;

  assign a_word_s = a_r[idx_r * 32 +: 32];
  assign b_word_s = b_r[idx_r * 32 +: 32];
  assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

  full_adder_32_bit u_adder (
    .a    (a_word_s),
    .b    (b_word_s),
    .cin  (carry_r),
    .s    (s_word_s),
    .cout (add_cout_s)
  );

  // Next-state decode; start is only honoured in IDLE (including the done cycle).
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, word-serial accumulation and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        // Subtraction is a + ~b + 1, so invert b once here and force carry-in.
        a_r     <= bus.a;
        b_r     <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.sub ? 1'b1 : bus.cin;
        idx_r   <= {IW{1'b0}};
        sum_r   <= {W{1'b0}};
        cout_r  <= 1'b0;
        ovf_r   <= 1'b0;
      end else if (state_r == RUN) begin
        sum_r[idx_r * 32 +: 32] <= s_word_s;
        carry_r <= add_cout_s;
        idx_r   <= idx_r + IW'(1);
        if (last_s) begin
          cout_r <= add_cout_s;
          done_r <= 1'b1;
          // Same operand signs but a result sign that differs means overflow.
          ovf_r  <= (a_r[W-1] == b_r[W-1]) && (s_word_s[31] != a_r[W-1]);
        end else begin
          cout_r <= cout_r;
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign bus.busy     = (state_r == RUN);
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: a 4-word instance for the
// main scenarios and a 1-word instance for the single-word case. Expected
// results come from plain wide arithmetic on the full operands.
module tb_wide_add_sequencer;
  logic clk;
  logic rst;

  wide_add_sequencer_if #(.WORDS(4)) bus4 ();
  wide_add_sequencer_if #(.WORDS(1)) bus1 ();

  wide_add_sequencer #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  wide_add_sequencer #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks;
  int failures;

  bit           cur_sel;   // 0: 4-word instance, 1: 1-word instance
  logic [127:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  logic [128:0] obs_sum;
  logic         obs_busy;
  logic         obs_done;
  logic         obs_cout;
  logic         obs_ovf;

  assign obs_sum  = cur_sel ? {97'd0, bus1.sum} : {1'b0, bus4.sum};
  assign obs_busy = cur_sel ? bus1.busy : bus4.busy;
  assign obs_done = cur_sel ? bus1.done : bus4.done;
  assign obs_cout = cur_sel ? bus1.cout : bus4.cout;
  assign obs_ovf  = cur_sel ? bus1.overflow : bus4.overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compute the expected result and raise start on the selected instance.
  task automatic issue(input bit sel, input logic [127:0] a, input logic [127:0] b,
                       input logic sub, input logic cin);
    int           n;
    logic [128:0] mask;
    logic [128:0] am;
    logic [128:0] bm;
    logic [128:0] full;
    logic         sa;
    logic         sb;
    logic         sr;
    n    = sel ? 32 : 128;
    mask = (129'd1 << n) - 129'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (sub) begin
      full     = (am - bm) & mask;
      exp_cout = (am >= bm);
    end else begin
      full     = am + bm + {128'd0, cin};
      exp_cout = full[n];
      full     = full & mask;
    end
    exp_sum = full[127:0];
    sa = am[n-1];
    sb = bm[n-1];
    sr = full[n-1];
    exp_ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    cur_sel = sel;
    if (sel) begin
      bus1.a = a[31:0]; bus1.b = b[31:0]; bus1.sub = sub; bus1.cin = cin; bus1.start = 1'b1;
    end else begin
      bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.cin = cin; bus4.start = 1'b1;
    end
  endtask

  // Called at the negedge where start was raised; returns at the done-cycle negedge.
  task automatic finish_op(input bit sel, input bit hold);
    int words;
    words = sel ? 1 : 4;
    @(negedge clk);
    for (int k = 1; k <= words; k++) begin
      // Scramble inputs after the start edge; the in-flight op must not see them.
      bus4.a = rnd128(); bus4.b = rnd128(); bus4.sub = 1'($urandom); bus4.cin = 1'($urandom);
      bus1.a = $urandom; bus1.b = $urandom; bus1.sub = 1'($urandom); bus1.cin = 1'($urandom);
      if (!hold) begin
        bus4.start = 1'b0;
        bus1.start = 1'b0;
      end
      check_eq("busy_run", {128'd0, obs_busy}, 129'd1);
      check_eq("done_early", {128'd0, obs_done}, 129'd0);
      @(negedge clk);
    end
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    check_eq("done_pulse", {128'd0, obs_done}, 129'd1);
    check_eq("busy_done", {128'd0, obs_busy}, 129'd0);
    check_eq("sum", obs_sum, {1'b0, exp_sum});
    check_eq("cout", {128'd0, obs_cout}, {128'd0, exp_cout});
    check_eq("overflow", {128'd0, obs_ovf}, {128'd0, exp_ovf});
  endtask

  // Idle cycles: no done, not busy, result held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("done_idle", {128'd0, obs_done}, 129'd0);
      check_eq("busy_idle", {128'd0, obs_busy}, 129'd0);
      check_eq("sum_hold", obs_sum, {1'b0, exp_sum});
    end
  endtask

  initial begin
    logic [127:0] ra;
    logic [127:0] rb;
    bit           chain;
    checks   = 0;
    failures = 0;
    cur_sel  = 1'b0;
    exp_sum  = 128'd0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = 128'd0; bus4.b = 128'd0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = 32'd0;  bus1.b = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {128'd0, bus4.busy}, 129'd0);
    check_eq("rst_done", {128'd0, bus4.done}, 129'd0);
    check_eq("rst_sum", {1'b0, bus4.sum}, 129'd0);
    check_eq("rst_cout", {128'd0, bus4.cout}, 129'd0);
    check_eq("rst_ovf", {128'd0, bus4.overflow}, 129'd0);
    check_eq("rst_sum1", {97'd0, bus1.sum}, 129'd0);
    rst = 1'b0;
    idle(1);

    // All-ones plus one: carry out of every word.
    issue(1'b0, {128{1'b1}}, 128'd1, 1'b0, 1'b0);
    finish_op(1'b0, 1'b0);
    idle(2);
    // Largest positive plus one: signed overflow.
    issue(1'b0, {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
    finish_op(1'b0, 1'b0);
    idle(1);
    // Subtraction with and without borrow.
    issue(1'b0, 128'd5, 128'd7, 1'b1, 1'b1);
    finish_op(1'b0, 1'b0);
    idle(1);
    issue(1'b0, 128'd7, 128'd5, 1'b1, 1'b0);
    finish_op(1'b0, 1'b0);
    idle(1);

    // Start held through RUN with changing operands: exactly one op.
    issue(1'b0, rnd128(), rnd128(), 1'b0, 1'b1);
    finish_op(1'b0, 1'b1);
    idle(3);
    // Start in the done cycle is accepted back to back.
    issue(1'b0, rnd128(), rnd128(), 1'b0, 1'b0);
    finish_op(1'b0, 1'b0);
    issue(1'b0, rnd128(), rnd128(), 1'b1, 1'b0);
    finish_op(1'b0, 1'b0);
    idle(1);

    // Reset during the second RUN cycle aborts the op.
    issue(1'b0, rnd128(), rnd128(), 1'b0, 1'b0);
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {128'd0, bus4.busy}, 129'd0);
    check_eq("abort_sum", {1'b0, bus4.sum}, 129'd0);
    check_eq("abort_cout", {128'd0, bus4.cout}, 129'd0);
    check_eq("abort_done", {128'd0, bus4.done}, 129'd0);
    rst = 1'b0;
    exp_sum = 128'd0;
    idle(4);
    issue(1'b0, rnd128(), rnd128(), 1'b0, 1'b1);
    finish_op(1'b0, 1'b0);
    idle(1);

    // Randomized 4-word operations, some chained into the done cycle.
    chain = 1'b0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: ra = {128{1'b1}};
        1: ra = {1'b0, {127{1'b1}}};
        2: ra = {1'b1, 127'd0};
        default: ra = rnd128();
      endcase
      rb = ($urandom_range(0, 3) == 0) ? {96'd0, $urandom} : rnd128();
      issue(1'b0, ra, rb, 1'($urandom), 1'($urandom));
      finish_op(1'b0, 1'($urandom));
      chain = 1'($urandom);
      if (!chain) begin
        idle($urandom_range(1, 2));
      end
    end
    idle(1);

    // Single-word instance.
    issue(1'b1, {96'd0, 32'hFFFF_FFFF}, 128'd1, 1'b0, 1'b1);
    finish_op(1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      issue(1'b1, {96'd0, $urandom}, {96'd0, $urandom}, 1'($urandom), 1'($urandom));
      finish_op(1'b1, 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        idle(1);
      end
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
